// File: rtl/xc_pkg.sv
// Shared types and constants for the writeback pipeline.
package xc_pkg;

    // Number of in-flight result stages (S0 forward, S1 forward, S2 commit).
    localparam int unsigned XC_WB_DEPTH = 3;

    // One in-flight register result.
    typedef struct packed {
        logic        valid;
        logic        wen;
        logic        wide;
        logic        pending;
        logic [4:0]  addr;
        logic [31:0] lo;
        logic [31:0] hi;
    } xc_wb_entry_t;

    // Empty slot loaded whenever a stage advances without new work.
    localparam xc_wb_entry_t XC_WB_BUBBLE = '0;

    // A narrow result is mirrored into both words so either register parity
    // reads the right value; a wide result keeps its separate high word.
    function automatic logic [31:0] xc_wb_hi_word(input logic        wide,
                                                  input logic [31:0] lo,
                                                  input logic [31:0] hi);
        return wide ? hi : lo;
    endfunction

endpackage

// File: rtl/xc_wb_stage.sv
// One writeback stage register: hold, load a new entry, or load a bubble.
module xc_wb_stage
    import xc_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         hold_i,
    input  logic         load_i,
    input  xc_wb_entry_t d_i,
    output xc_wb_entry_t q_o
);

    xc_wb_entry_t entry_q;
    xc_wb_entry_t entry_d;

    // Next-state select: hold has priority, otherwise load or bubble.
    always_comb begin
        entry_d = XC_WB_BUBBLE;
        if (hold_i) begin
            entry_d = entry_q;
        end else if (load_i) begin
            entry_d = d_i;
        end
    end

    // Entry register, cleared asynchronously so in-flight work is dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            entry_q <= XC_WB_BUBBLE;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign q_o = entry_q;

endmodule

// File: rtl/xc_wb_pipe.sv
// Writeback pipeline: S0/S1 feed the forwarding ports, S2 commits to the
// register file; late results park in S0 and raise decode hazards.
//
// Handshake: a result transfers into S0 on a rising edge where
// ex_valid && ex_ready; ex_ready is combinational and drops only while S0
// holds a pending entry whose late data has not arrived; ex_* must stay
// stable while ex_valid is high and ex_ready is low.
module xc_wb_pipe
    import xc_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_wen,
    input  logic        ex_wide,
    input  logic        ex_late,
    input  logic [4:0]  ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] ex_wdata_hi,
    input  logic        late_valid,
    input  logic [31:0] late_wdata,
    input  logic [31:0] late_wdata_hi,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        rs1_hazard,
    output logic        rs2_hazard,
    output logic        fwd_0_wen,
    output logic        fwd_0_wide,
    output logic [4:0]  fwd_0_addr,
    output logic [31:0] fwd_0_wdata,
    output logic [31:0] fwd_0_wdata_hi,
    output logic        fwd_1_wen,
    output logic        fwd_1_wide,
    output logic [4:0]  fwd_1_addr,
    output logic [31:0] fwd_1_wdata,
    output logic [31:0] fwd_1_wdata_hi,
    output logic        rd_wen,
    output logic        rd_wide,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_wdata,
    output logic [31:0] rd_wdata_hi,
    output logic        busy
);

    xc_wb_entry_t stage_q [XC_WB_DEPTH];
    xc_wb_entry_t s0_d;
    xc_wb_entry_t s1_d;
    logic         s0_blocked;
    logic         s0_pend;

    // S0 stalls only while it waits for late data that has not yet arrived.
    assign s0_pend    = stage_q[0].valid && stage_q[0].pending;
    assign s0_blocked = s0_pend && !late_valid;
    assign ex_ready   = !s0_blocked;

    // Capture normalisation for a newly accepted execute result.
    always_comb begin
        s0_d         = XC_WB_BUBBLE;
        s0_d.valid   = 1'b1;
        s0_d.wide    = ex_wide;
        s0_d.addr    = ex_wide ? {ex_addr[4:1], 1'b0} : ex_addr;
        s0_d.wen     = ex_wen && (ex_wide || (ex_addr != 5'd0));
        s0_d.pending = ex_late && ex_wen;
        if (!ex_late) begin
            s0_d.lo = ex_wdata;
            s0_d.hi = xc_wb_hi_word(ex_wide, ex_wdata, ex_wdata_hi);
        end
    end

    // S1 takes S0 as-is, or completes a pending S0 with the late data.
    always_comb begin
        s1_d = stage_q[0];
        if (s0_pend) begin
            s1_d.pending = 1'b0;
            s1_d.lo      = late_wdata;
            s1_d.hi      = xc_wb_hi_word(stage_q[0].wide, late_wdata, late_wdata_hi);
        end
    end

    xc_wb_stage u_s0 (
        .clock  (clock),
        .reset  (reset),
        .hold_i (s0_blocked),
        .load_i (ex_valid),
        .d_i    (s0_d),
        .q_o    (stage_q[0])
    );

    xc_wb_stage u_s1 (
        .clock  (clock),
        .reset  (reset),
        .hold_i (1'b0),
        .load_i (!s0_blocked),
        .d_i    (s1_d),
        .q_o    (stage_q[1])
    );

    xc_wb_stage u_s2 (
        .clock  (clock),
        .reset  (reset),
        .hold_i (1'b0),
        .load_i (1'b1),
        .d_i    (stage_q[1]),
        .q_o    (stage_q[2])
    );

    // Forward and commit ports, zeroed whenever the write enable is low.
    always_comb begin
        fwd_0_wen      = stage_q[0].valid && stage_q[0].wen && !stage_q[0].pending;
        fwd_0_wide     = fwd_0_wen && stage_q[0].wide;
        fwd_0_addr     = fwd_0_wen ? stage_q[0].addr : 5'd0;
        fwd_0_wdata    = fwd_0_wen ? stage_q[0].lo : 32'd0;
        fwd_0_wdata_hi = fwd_0_wen ? stage_q[0].hi : 32'd0;

        fwd_1_wen      = stage_q[1].valid && stage_q[1].wen && !stage_q[1].pending;
        fwd_1_wide     = fwd_1_wen && stage_q[1].wide;
        fwd_1_addr     = fwd_1_wen ? stage_q[1].addr : 5'd0;
        fwd_1_wdata    = fwd_1_wen ? stage_q[1].lo : 32'd0;
        fwd_1_wdata_hi = fwd_1_wen ? stage_q[1].hi : 32'd0;

        rd_wen         = stage_q[2].valid && stage_q[2].wen && !stage_q[2].pending;
        rd_wide        = rd_wen && stage_q[2].wide;
        rd_addr        = rd_wen ? stage_q[2].addr : 5'd0;
        rd_wdata       = rd_wen ? stage_q[2].lo : 32'd0;
        rd_wdata_hi    = rd_wen ? stage_q[2].hi : 32'd0;
    end

    // Decode hazard: a source matches the register S0 is still waiting on.
    always_comb begin
        logic pend_wr;
        pend_wr    = s0_pend && stage_q[0].wen;
        rs1_hazard = 1'b0;
        rs2_hazard = 1'b0;
        if (pend_wr) begin
            if (stage_q[0].wide) begin
                rs1_hazard = (rs1_addr != 5'd0) && (rs1_addr[4:1] == stage_q[0].addr[4:1]);
                rs2_hazard = (rs2_addr != 5'd0) && (rs2_addr[4:1] == stage_q[0].addr[4:1]);
            end else begin
                rs1_hazard = (rs1_addr != 5'd0) && (rs1_addr == stage_q[0].addr);
                rs2_hazard = (rs2_addr != 5'd0) && (rs2_addr == stage_q[0].addr);
            end
        end
    end

    // Busy while any stage still holds an entry.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < XC_WB_DEPTH; i++) begin
            busy = busy | stage_q[i].valid;
        end
    end

endmodule

// File: tb/tb_xc_wb_pipe.sv
// Directed bench for xc_wb_pipe with hand-computed expectations.
module tb_xc_wb_pipe;

    logic        clock;
    logic        reset;
    logic        ex_valid, ex_ready, ex_wen, ex_wide, ex_late;
    logic [4:0]  ex_addr;
    logic [31:0] ex_wdata, ex_wdata_hi;
    logic        late_valid;
    logic [31:0] late_wdata, late_wdata_hi;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rs1_hazard, rs2_hazard;
    logic        fwd_0_wen, fwd_0_wide;
    logic [4:0]  fwd_0_addr;
    logic [31:0] fwd_0_wdata, fwd_0_wdata_hi;
    logic        fwd_1_wen, fwd_1_wide;
    logic [4:0]  fwd_1_addr;
    logic [31:0] fwd_1_wdata, fwd_1_wdata_hi;
    logic        rd_wen, rd_wide;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata, rd_wdata_hi;
    logic        busy;

    int n_checks;
    int n_errors;

    xc_wb_pipe dut (
        .clock          (clock),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_wen         (ex_wen),
        .ex_wide        (ex_wide),
        .ex_late        (ex_late),
        .ex_addr        (ex_addr),
        .ex_wdata       (ex_wdata),
        .ex_wdata_hi    (ex_wdata_hi),
        .late_valid     (late_valid),
        .late_wdata     (late_wdata),
        .late_wdata_hi  (late_wdata_hi),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rs1_hazard     (rs1_hazard),
        .rs2_hazard     (rs2_hazard),
        .fwd_0_wen      (fwd_0_wen),
        .fwd_0_wide     (fwd_0_wide),
        .fwd_0_addr     (fwd_0_addr),
        .fwd_0_wdata    (fwd_0_wdata),
        .fwd_0_wdata_hi (fwd_0_wdata_hi),
        .fwd_1_wen      (fwd_1_wen),
        .fwd_1_wide     (fwd_1_wide),
        .fwd_1_addr     (fwd_1_addr),
        .fwd_1_wdata    (fwd_1_wdata),
        .fwd_1_wdata_hi (fwd_1_wdata_hi),
        .rd_wen         (rd_wen),
        .rd_wide        (rd_wide),
        .rd_addr        (rd_addr),
        .rd_wdata       (rd_wdata),
        .rd_wdata_hi    (rd_wdata_hi),
        .busy           (busy)
    );

    // Clock: 10 time-unit period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Immediate-assertion compare with failure accounting.
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are changed and outputs sampled away from the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_ex(input logic wen, input logic wide, input logic late,
                            input logic [4:0] addr, input logic [31:0] lo,
                            input logic [31:0] hi);
        ex_valid    = 1'b1;
        ex_wen      = wen;
        ex_wide     = wide;
        ex_late     = late;
        ex_addr     = addr;
        ex_wdata    = lo;
        ex_wdata_hi = hi;
    endtask

    task automatic idle_ex();
        ex_valid    = 1'b0;
        ex_wen      = 1'b0;
        ex_wide     = 1'b0;
        ex_late     = 1'b0;
        ex_addr     = 5'd0;
        ex_wdata    = 32'd0;
        ex_wdata_hi = 32'd0;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        late_valid    = 1'b0;
        late_wdata    = 32'd0;
        late_wdata_hi = 32'd0;
        rs1_addr      = 5'd0;
        rs2_addr      = 5'd0;
        idle_ex();
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state
        chk("rst_ex_ready", ex_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_fwd0_wen", fwd_0_wen, 0);
        chk("rst_rd_wen", rd_wen, 0);

        // Narrow write x5
        drive_ex(1, 0, 0, 5'd5, 32'h12345678, 32'h0);
        tick();
        idle_ex();
        #1;
        chk("nar_fwd0_wen", fwd_0_wen, 1);
        chk("nar_fwd0_addr", fwd_0_addr, 5);
        chk("nar_fwd0_lo", fwd_0_wdata, 32'h12345678);
        chk("nar_fwd0_hi", fwd_0_wdata_hi, 32'h12345678);
        chk("nar_fwd1_early", fwd_1_wen, 0);
        tick();
        chk("nar_fwd1_wen", fwd_1_wen, 1);
        chk("nar_fwd1_addr", fwd_1_addr, 5);
        chk("nar_fwd0_gone", fwd_0_wen, 0);
        chk("nar_rd_early", rd_wen, 0);
        tick();
        chk("nar_rd_wen", rd_wen, 1);
        chk("nar_rd_addr", rd_addr, 5);
        chk("nar_rd_lo", rd_wdata, 32'h12345678);
        chk("nar_rd_hi", rd_wdata_hi, 32'h12345678);
        tick();
        chk("nar_rd_once", rd_wen, 0);
        chk("nar_idle", busy, 0);

        // Wide write to odd address 7
        drive_ex(1, 1, 0, 5'd7, 32'hA, 32'hB);
        tick();
        idle_ex();
        #1;
        chk("wide_fwd0_addr", fwd_0_addr, 6);
        chk("wide_fwd0_wide", fwd_0_wide, 1);
        tick();
        tick();
        chk("wide_rd_wen", rd_wen, 1);
        chk("wide_rd_addr", rd_addr, 6);
        chk("wide_rd_wide", rd_wide, 1);
        chk("wide_rd_lo", rd_wdata, 32'hA);
        chk("wide_rd_hi", rd_wdata_hi, 32'hB);
        tick();

        // Late write x10, data in cycle t+3, x12 accepted alongside
        drive_ex(1, 0, 1, 5'd10, 32'hBAD0BAD0, 32'hBAD1BAD1);
        tick();
        idle_ex();
        for (int c = 1; c <= 2; c++) begin
            rs1_addr = 5'd10;
            rs2_addr = 5'd10;
            #1;
            chk("late_ready_lo", ex_ready, 0);
            chk("late_rs1_hit", rs1_hazard, 1);
            chk("late_rs2_hit", rs2_hazard, 1);
            chk("late_fwd0_wen", fwd_0_wen, 0);
            chk("late_fwd1_wen", fwd_1_wen, 0);
            rs1_addr = 5'd11;
            #1;
            chk("late_rs1_miss", rs1_hazard, 0);
            tick();
        end
        rs1_addr      = 5'd0;
        rs2_addr      = 5'd0;
        late_valid    = 1'b1;
        late_wdata    = 32'hDEADBEEF;
        late_wdata_hi = 32'hCAFEF00D;
        drive_ex(1, 0, 0, 5'd12, 32'h55, 32'h0);
        #1;
        chk("late_ready_hi", ex_ready, 1);
        tick();
        late_valid = 1'b0;
        idle_ex();
        #1;
        chk("late_fwd1_wen", fwd_1_wen, 1);
        chk("late_fwd1_addr", fwd_1_addr, 10);
        chk("late_fwd1_lo", fwd_1_wdata, 32'hDEADBEEF);
        chk("late_fwd1_hi", fwd_1_wdata_hi, 32'hDEADBEEF);
        chk("late_next_fwd0", fwd_0_addr, 12);
        chk("late_next_data", fwd_0_wdata, 32'h55);
        tick();
        chk("late_rd_wen", rd_wen, 1);
        chk("late_rd_addr", rd_addr, 10);
        chk("late_rd_lo", rd_wdata, 32'hDEADBEEF);
        chk("late_next_fwd1", fwd_1_addr, 12);
        tick();
        chk("late_next_rd", rd_addr, 12);
        tick();

        // Narrow write to x0
        drive_ex(1, 0, 0, 5'd0, 32'hFFFFFFFF, 32'h0);
        tick();
        idle_ex();
        rs1_addr = 5'd0;
        #1;
        chk("x0_fwd0_wen", fwd_0_wen, 0);
        chk("x0_fwd0_data", fwd_0_wdata, 0);
        chk("x0_busy", busy, 1);
        chk("x0_hazard", rs1_hazard, 0);
        tick();
        chk("x0_fwd1_wen", fwd_1_wen, 0);
        tick();
        chk("x0_rd_wen", rd_wen, 0);
        tick();

        // Stray late data with a non-pending entry in S0
        drive_ex(1, 0, 0, 5'd4, 32'h44, 32'h0);
        tick();
        idle_ex();
        late_valid = 1'b1;
        late_wdata = 32'h99999999;
        #1;
        chk("stray_ready", ex_ready, 1);
        tick();
        late_valid = 1'b0;
        #1;
        chk("stray_fwd1_data", fwd_1_wdata, 32'h44);
        chk("stray_fwd1_hi", fwd_1_wdata_hi, 32'h44);
        tick();
        tick();
        late_valid = 1'b1;
        #1;
        chk("stray_idle_busy", busy, 0);
        tick();
        late_valid = 1'b0;
        #1;
        chk("stray_idle_fwd1", fwd_1_wen, 0);
        chk("stray_idle_busy2", busy, 0);

        // Back-to-back x1, x2, x3
        for (int i = 1; i <= 3; i++) begin
            drive_ex(1, 0, 0, 5'(i), 32'(i * 32'h11), 32'h0);
            tick();
        end
        idle_ex();
        #1;
        chk("b2b_rd1_wen", rd_wen, 1);
        chk("b2b_rd1_addr", rd_addr, 1);
        chk("b2b_rd1_data", rd_wdata, 32'h11);
        tick();
        chk("b2b_rd2_wen", rd_wen, 1);
        chk("b2b_rd2_addr", rd_addr, 2);
        tick();
        chk("b2b_rd3_wen", rd_wen, 1);
        chk("b2b_rd3_addr", rd_addr, 3);
        chk("b2b_rd3_data", rd_wdata, 32'h33);
        tick();
        chk("b2b_rd_end", rd_wen, 0);

        // Reset with all stages full
        for (int i = 1; i <= 3; i++) begin
            drive_ex(1, 0, 0, 5'(i), 32'(i * 32'h11), 32'h0);
            tick();
        end
        idle_ex();
        #1;
        chk("full_busy", busy, 1);
        chk("full_fwd0_wen", fwd_0_wen, 1);
        reset = 1'b1;
        #1;
        chk("arst_rd_wen", rd_wen, 0);
        chk("arst_fwd0_wen", fwd_0_wen, 0);
        chk("arst_fwd1_wen", fwd_1_wen, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ex_ready", ex_ready, 1);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("post_rst_rd", rd_wen, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
